vjtag_debug_host: RTL and testbench
===================================

Name: vjtag_debug_host

Overview:
- Initiator end of the 2-bit-IR virtual-JTAG debug interface consumed by the Nios II CPU debug slave.
- Converts a command (IR select plus DR payload) into a cycle-accurate virtual-JTAG sequence, UIR → CDR → SDR ×DR_WIDTH → UDR → RTI.
- Returns the DR bits captured from tdo, plus the ir_out value.
- Used as an on-chip debug master and as the simulation driver in place of the physical JTAG hub.

Parameters:
- DR_WIDTH, 38: DR shift length in bits; must match the slave's jdo/sr width.
- TCK_HALF, 2: clk cycles per TCK half-period; minimum 1.
- RTI_CYCLES, 2: number of TCK periods spent in run-test-idle after each UDR; minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  host can accept a command
- cmd_ir  in  2  IR value driven on vji_ir_in
- cmd_data  in  DR_WIDTH  DR payload, shifted LSB first
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  DR_WIDTH  DR bits captured from tdo
- rsp_ir_out  out  2  vji_ir_out sampled during the UIR step
- vji_tck  out  1  generated TCK
- vji_tdi  out  1  serial data to the slave
- vji_tdo  in  1  serial data from the slave
- vji_ir_in  out  2  IR to the slave
- vji_ir_out  in  2  IR status from the slave
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state strobes

Behaviour:
- Single clock domain. Reset is synchronous and active-high; clock port is clk, reset port is reset.
- Reset values:
  - State IDLE.
  - cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_ir_out=0.
  - vji_tck=0, vji_tdi=0, vji_ir_in=0.
  - All strobes 0.
  - Internal last_ir=0, last_ir_vld=0.
- Step timing:
  - One step = 2*TCK_HALF clk cycles: TCK low for TCK_HALF cycles, then high for TCK_HALF cycles.
  - Strobes, tdi and ir_in change only on the first clk cycle of a step, i.e. at TCK falling edge.
  - vji_tdo and vji_ir_out are sampled on the last clk cycle of the step, the final high-phase cycle.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - On accept: cmd_data is latched into shift register sr, cmd_ir into ir_q, and cmd_ready falls on the next cycle.
  - cmd_ready stays 0 until the response is consumed: rsp_valid && rsp_ready.
  - Response and cmd_ready rise together. A new command may be accepted in that same cycle.
- FSM sequence: IDLE → UIR → CDR → SDR → UDR → RTI → RSP → IDLE.
  - UIR (1 step): vji_uir=1, vji_ir_in=ir_q; sample vji_ir_out into rsp_ir_out.
  - CDR (1 step): vji_cdr=1.
  - SDR (DR_WIDTH steps):
    - vji_sdr=1, vji_tdi=sr[0].
    - At step end: sr <= {tdo_sample, sr[DR_WIDTH-1:1]}.
    - A bit counter counts 0..DR_WIDTH-1. Leave SDR when the counter reaches DR_WIDTH-1 at step end. There is no wrap beyond that.
  - UDR (1 step): vji_udr=1; tdi=0.
  - RTI (RTI_CYCLES steps): vji_rti=1.
  - RSP: TCK is held low, all strobes are 0, rsp_data=sr, rsp_valid=1.
    - rsp_valid is held, with data stable, until rsp_ready.
    - IDLE is re-entered on the same cycle the response is consumed.
  - Exactly one strobe is active at a time, except in IDLE/RSP, where all are 0.
  - vji_ir_in holds ir_q from UIR until the next command's UIR.
- Latency: accept at cycle N → rsp_valid first high at N+1+(3+DR_WIDTH+RTI_CYCLES)*2*TCK_HALF. Defaults give N+173.
- rsp_ready asserted while not in RSP is ignored.
- cmd_valid while busy is ignored and not stored.
- Reset mid-operation: the sequence is abandoned with no UDR issued, outputs return to reset values on the next cycle, and any pending response is discarded.

Optional Feature:
- Macro VJTAG_HOST_IR_SKIP_EN.
- Defined:
  - After each completed UIR step, last_ir<=ir_q and last_ir_vld<=1.
  - A command whose cmd_ir equals last_ir while last_ir_vld=1 skips the UIR step and goes straight to CDR. Latency is reduced by 2*TCK_HALF.
  - rsp_ir_out holds its previous value.
  - Reset clears last_ir_vld.
- Undefined: UIR is always issued; last_ir logic is absent.

Test Plan:
- Reset, then idle 10 cycles → cmd_ready=1, rsp_valid=0, tck=0, all strobes 0.
- cmd_ir=2'b01, cmd_data=38'h2A_5555_AAAA; slave model loops tdi back to tdo → tdi bit sequence on sdr equals cmd_data LSB-first; rsp_data=38'h2A_5555_AAAA; rsp_valid first at accept+173; uir/cdr/udr each high 4 cycles; rti high 8 cycles.
- Slave model drives tdo=1 and vji_ir_out=2'b10 → rsp_data=38'h3F_FFFF_FFFF, rsp_ir_out=2'b10.
- Hold rsp_ready=0 for 20 cycles after rsp_valid → rsp_data stable, cmd_ready=0, a second cmd_valid pulse is ignored; when rsp_ready=1, the next command is accepted that cycle.
- Assert reset at SDR bit 17 → next cycle all strobes 0, tck=0, cmd_ready=1, no udr ever seen, no response.
- With VJTAG_HOST_IR_SKIP_EN: two commands with ir=2'b11 → second has no uir pulse and rsp_valid at accept+169; third with ir=2'b00 → uir present.

Source files
------------

// File: rtl/vjtag_debug_host.sv
`default_nettype none
// ============================================================================
//  Module      : vjtag_debug_host
//  Description : Initiator side of a 2-bit-IR virtual-JTAG debug link.
//                Turns one command (IR select + DR payload) into the
//                step sequence UIR -> CDR -> SDR x DR_WIDTH -> UDR -> RTI.
//                Returns the DR bits shifted in from vji_tdo and the
//                vji_ir_out value seen during UIR.
//
//  Ports       : clk, reset             - clock, synchronous active-high reset
//                cmd_valid/ready        - command handshake
//                cmd_ir, cmd_data       - IR select and DR payload (LSB first)
//                rsp_valid/ready        - response handshake
//                rsp_data, rsp_ir_out   - captured DR bits and IR status
//                vji_tck/tdi/tdo        - generated TCK and serial data
//                vji_ir_in/ir_out       - IR to / status from the slave
//                vji_uir/cdr/sdr/udr/rti- virtual state strobes
//
//  Parameters  : DR_WIDTH   (>= 2) DR shift length
//                TCK_HALF   (>= 1) clk cycles per TCK half period
//                RTI_CYCLES (>= 1) TCK periods spent in run-test-idle
//
//  Option      : VJTAG_HOST_IR_SKIP_EN - when defined, the UIR step is
//                skipped if the command repeats the last IR issued.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module vjtag_debug_host #(
    parameter int DR_WIDTH   = 38,
    parameter int TCK_HALF   = 2,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [1:0]          rsp_ir_out,

    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [1:0]          vji_ir_in,
    input  logic [1:0]          vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_STEP    = 2 * TCK_HALF;
    localparam int c_PW      = $clog2(c_STEP);
    localparam int c_CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_PW-1:0] c_PH_HIGH  = c_PW'(TCK_HALF);
    localparam logic [c_PW-1:0] c_PH_LAST  = c_PW'(c_STEP - 1);
    localparam logic [c_CW-1:0] c_DR_LAST  = c_CW'(DR_WIDTH - 1);
    localparam logic [c_CW-1:0] c_RTI_LAST = c_CW'(RTI_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UIR  = 3'd1,
        S_CDR  = 3'd2,
        S_SDR  = 3'd3,
        S_UDR  = 3'd4,
        S_RTI  = 3'd5,
        S_RSP  = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_PW-1:0]       r_phase;
    logic [c_CW-1:0]       r_cnt;
    logic [DR_WIDTH-1:0]   r_sr;
    logic [1:0]            r_ir_q;
    logic [DR_WIDTH-1:0]   r_rsp_data;
    logic [1:0]            r_rsp_ir_out;

    logic                  w_step_end;
    logic                  w_tck_high;
    logic                  w_cmd_ready;
    logic                  w_accept;
    logic                  w_skip;
    logic                  w_active;

    // Phase within a TCK step: low half first, high half second. The last
    // cycle of the step is where slave outputs are sampled and where the
    // FSM advances, so new strobes appear on the first (TCK-falling) cycle.
    assign w_step_end = (r_phase == c_PH_LAST);
    assign w_tck_high = (r_phase >= c_PH_HIGH);
    assign w_active   = (r_state != S_IDLE) && (r_state != S_RSP);

    // A command can be taken while idle, or in the same cycle the pending
    // response is consumed (back-to-back operation).
    assign w_cmd_ready = (r_state == S_IDLE) ||
                         ((r_state == S_RSP) && rsp_ready);
    assign w_accept    = cmd_valid && w_cmd_ready;

    // ------------------------------------------------------------------
    // Optional IR-skip tracking
    // ------------------------------------------------------------------
`ifdef VJTAG_HOST_IR_SKIP_EN
    logic [1:0] r_last_ir;
    logic       r_last_ir_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_ir     <= 2'b00;
            r_last_ir_vld <= 1'b0;
        end else if ((r_state == S_UIR) && w_step_end) begin
            r_last_ir     <= r_ir_q;
            r_last_ir_vld <= 1'b1;
        end
    end

    assign w_skip = r_last_ir_vld && (cmd_ir == r_last_ir);
`else
    assign w_skip = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_skip ? S_CDR : S_UIR;
                end
            end
            S_UIR: begin
                if (w_step_end) begin
                    w_state_nxt = S_CDR;
                end
            end
            S_CDR: begin
                if (w_step_end) begin
                    w_state_nxt = S_SDR;
                end
            end
            S_SDR: begin
                if (w_step_end && (r_cnt == c_DR_LAST)) begin
                    w_state_nxt = S_UDR;
                end
            end
            S_UDR: begin
                if (w_step_end) begin
                    w_state_nxt = S_RTI;
                end
            end
            S_RTI: begin
                if (w_step_end && (r_cnt == c_RTI_LAST)) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    if (cmd_valid) begin
                        w_state_nxt = w_skip ? S_CDR : S_UIR;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        vji_tck = 1'b0;
        vji_tdi = 1'b0;
        vji_uir = 1'b0;
        vji_cdr = 1'b0;
        vji_sdr = 1'b0;
        vji_udr = 1'b0;
        vji_rti = 1'b0;
        if (w_active) begin
            vji_tck = w_tck_high;
        end
        unique case (r_state)
            S_UIR:   vji_uir = 1'b1;
            S_CDR:   vji_cdr = 1'b1;
            S_SDR: begin
                vji_sdr = 1'b1;
                vji_tdi = r_sr[0];
            end
            S_UDR:   vji_udr = 1'b1;
            S_RTI:   vji_rti = 1'b1;
            default: ;
        endcase
    end

    assign cmd_ready  = w_cmd_ready;
    assign rsp_valid  = (r_state == S_RSP);
    assign rsp_data   = r_rsp_data;
    assign rsp_ir_out = r_rsp_ir_out;
    // ir_q is loaded at accept, which is also the cycle UIR begins, so the
    // slave sees the new IR exactly when the UIR strobe rises.
    assign vji_ir_in  = r_ir_q;

    // ------------------------------------------------------------------
    // Step phase and step counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= '0;
        end else if (!w_active || w_step_end) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    // Counts SDR bits and RTI periods; restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (w_step_end && ((r_state == S_SDR) || (r_state == S_RTI))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Data path
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr   <= '0;
            r_ir_q <= 2'b00;
        end else if (w_accept) begin
            r_sr   <= cmd_data;
            r_ir_q <= cmd_ir;
        end else if ((r_state == S_SDR) && w_step_end) begin
            // tdo enters at the top so that after DR_WIDTH shifts the first
            // captured bit sits at bit 0, matching the LSB-first payload.
            r_sr <= {vji_tdo, r_sr[DR_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_ir_out <= 2'b00;
        end else if ((r_state == S_UIR) && w_step_end) begin
            r_rsp_ir_out <= vji_ir_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_data <= '0;
        end else if ((r_state == S_RTI) && (w_state_nxt == S_RSP)) begin
            r_rsp_data <= r_sr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vjtag_debug_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vjtag_debug_host
//  Description : Self-checking bench for vjtag_debug_host (default params).
//                Table of directed commands with hand-computed responses,
//                plus sequences for response back-pressure and mid-shift
//                reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vjtag_debug_host;

    localparam int c_LAT_FULL = 173;
    localparam int c_LAT_SKIP = 169;
`ifdef VJTAG_HOST_IR_SKIP_EN
    localparam bit c_SKIP_EN = 1'b1;
`else
    localparam bit c_SKIP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_ir = 2'b00;
    logic [37:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [37:0] rsp_data;
    logic [1:0]  rsp_ir_out;
    logic        vji_tck, vji_tdi, vji_tdo;
    logic [1:0]  vji_ir_in;
    logic [1:0]  vji_ir_out;
    logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

    // slave model controls: 0 = loopback tdi->tdo, 1 = tdo high, 2 = tdo low
    int          tdo_mode = 0;
    logic [1:0]  drv_ir_out = 2'b00;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          accept_cyc = 0;

    // monitor state (written only by the monitor process)
    int          n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_rti = 0;
    int          n_bits = 0, n_excl = 0, n_rspv = 0;
    logic [37:0] tdi_sr = '0;
    logic        prev_tck = 1'b0;

    vjtag_debug_host dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ir     (cmd_ir),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_ir_out (rsp_ir_out),
        .vji_tck    (vji_tck),
        .vji_tdi    (vji_tdi),
        .vji_tdo    (vji_tdo),
        .vji_ir_in  (vji_ir_in),
        .vji_ir_out (vji_ir_out),
        .vji_uir    (vji_uir),
        .vji_cdr    (vji_cdr),
        .vji_sdr    (vji_sdr),
        .vji_udr    (vji_udr),
        .vji_rti    (vji_rti)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign vji_tdo    = (tdo_mode == 0) ? vji_tdi : (tdo_mode == 1);
    assign vji_ir_out = drv_ir_out;

    always @(negedge clk) begin
        if (vji_uir) n_uir++;
        if (vji_cdr) n_cdr++;
        if (vji_sdr) n_sdr++;
        if (vji_udr) n_udr++;
        if (vji_rti) n_rti++;
        if (rsp_valid) n_rspv++;
        if ((int'(vji_uir) + int'(vji_cdr) + int'(vji_sdr) + int'(vji_udr) + int'(vji_rti)) > 1)
            n_excl++;
        if (vji_tck && !prev_tck && vji_sdr) begin
            tdi_sr = {vji_tdi, tdi_sr[37:1]};
            n_bits++;
        end
        prev_tck = vji_tck;
    end

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] data;
        int          tdo;
        logic [1:0]  ir_out;
        logic [37:0] exp_data;
        logic [1:0]  exp_ir_out;
        bit          skips;        // repeats previous IR
        logic [1:0]  exp_ir_skip;  // rsp_ir_out if UIR is skipped
    } vec_t;

    vec_t vecs [5];

    int b_uir, b_cdr, b_sdr, b_udr, b_rti, b_excl, b_bits, b_rspv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        b_uir = n_uir; b_cdr = n_cdr; b_sdr = n_sdr; b_udr = n_udr;
        b_rti = n_rti; b_excl = n_excl; b_bits = n_bits; b_rspv = n_rspv;
    endtask

    task automatic wait_rsp(output int lat);
        bit got = 1'b0;
        lat = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("rsp_timeout", 64'(got), 64'd1);
        lat = cyc - accept_cyc;
    endtask

    task automatic issue(input logic [1:0] ir, input logic [37:0] data);
        tick();
        check("ready_before_cmd", 64'(cmd_ready), 64'd1);
        cmd_ir    = ir;
        cmd_data  = data;
        cmd_valid = 1'b1;
        snap();
        accept_cyc = cyc;
        tick();
        cmd_valid = 1'b0;
        check("ready_after_accept", 64'(cmd_ready), 64'd0);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_after_consume", 64'(rsp_valid), 64'd0);
        check("ready_after_consume", 64'(cmd_ready), 64'd1);
    endtask

    task automatic check_seq(input logic [37:0] data, input int exp_uir);
        check("uir_cycles", 64'(n_uir - b_uir), 64'(exp_uir));
        check("cdr_cycles", 64'(n_cdr - b_cdr), 64'd4);
        check("sdr_cycles", 64'(n_sdr - b_sdr), 64'd152);
        check("udr_cycles", 64'(n_udr - b_udr), 64'd4);
        check("rti_cycles", 64'(n_rti - b_rti), 64'd8);
        check("sdr_bits", 64'(n_bits - b_bits), 64'd38);
        check("tdi_seq", 64'(tdi_sr), 64'(data));
        check("strobe_exclusive", 64'(n_excl - b_excl), 64'd0);
    endtask

    initial begin
        int lat;
        int unstable;
        int busy_err;
        bit skip_now;

        vecs[0] = '{2'b01, 38'h2A_5555_AAAA, 0, 2'b00, 38'h2A_5555_AAAA, 2'b00, 1'b0, 2'b00};
        vecs[1] = '{2'b10, 38'h00_1234_5678, 1, 2'b10, 38'h3F_FFFF_FFFF, 2'b10, 1'b0, 2'b00};
        vecs[2] = '{2'b11, 38'h15_0F0F_F0F0, 2, 2'b01, 38'h00_0000_0000, 2'b01, 1'b0, 2'b00};
        vecs[3] = '{2'b11, 38'h3F_0000_0001, 0, 2'b10, 38'h3F_0000_0001, 2'b10, 1'b1, 2'b01};
        vecs[4] = '{2'b00, 38'h01_8000_0003, 0, 2'b11, 38'h01_8000_0003, 2'b11, 1'b0, 2'b00};

        // ---------------- reset state ----------------
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data", 64'(rsp_data), 64'd0);
        check("reset_rsp_ir_out", 64'(rsp_ir_out), 64'd0);
        check("reset_tck", 64'(vji_tck), 64'd0);
        check("reset_tdi", 64'(vji_tdi), 64'd0);
        check("reset_ir_in", 64'(vji_ir_in), 64'd0);
        check("reset_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);

        // ---------------- table-driven commands ----------------
        for (int v = 0; v < 5; v++) begin
            skip_now   = c_SKIP_EN && vecs[v].skips;
            tdo_mode   = vecs[v].tdo;
            drv_ir_out = vecs[v].ir_out;
            issue(vecs[v].ir, vecs[v].data);
            check("ir_in", 64'(vji_ir_in), 64'(vecs[v].ir));
            wait_rsp(lat);
            check("latency", 64'(lat), skip_now ? 64'(c_LAT_SKIP) : 64'(c_LAT_FULL));
            check("rsp_data", 64'(rsp_data), 64'(vecs[v].exp_data));
            check("rsp_ir_out", 64'(rsp_ir_out),
                  skip_now ? 64'(vecs[v].exp_ir_skip) : 64'(vecs[v].exp_ir_out));
            check("rsp_tck_low", 64'(vji_tck), 64'd0);
            check_seq(vecs[v].data, skip_now ? 0 : 4);
            consume();
        end

        // ---------------- response back-pressure ----------------
        tdo_mode   = 0;
        drv_ir_out = 2'b00;
        issue(2'b01, 38'h0A_DEAD_BEEF);
        wait_rsp(lat);
        check("hold_latency", 64'(lat), 64'(c_LAT_FULL));
        unstable = 0;
        busy_err = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_data !== 38'h0A_DEAD_BEEF) unstable++;
            if (cmd_ready !== 1'b0) busy_err++;
            if (i == 5) begin
                cmd_valid = 1'b1;
                cmd_ir    = 2'b11;
                cmd_data  = 38'h11_1111_1111;
            end
            if (i == 6) cmd_valid = 1'b0;
        end
        check("hold_data_stable", 64'(unstable), 64'd0);
        check("hold_ready_low", 64'(busy_err), 64'd0);
        check("hold_rsp_valid", 64'(rsp_valid), 64'd1);

        // consume and accept the next command in the same cycle
        tick();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_ir    = 2'b10;
        cmd_data  = 38'h25_0123_4567;
        #1;
        check("b2b_ready", 64'(cmd_ready), 64'd1);
        snap();
        accept_cyc = cyc;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("b2b_rsp_dropped", 64'(rsp_valid), 64'd0);
        check("b2b_busy", 64'(cmd_ready), 64'd0);
        check("b2b_ir_in", 64'(vji_ir_in), 64'd2);
        wait_rsp(lat);
        check("b2b_latency", 64'(lat), 64'(c_LAT_FULL));
        check("b2b_rsp_data", 64'(rsp_data), 64'(38'h25_0123_4567));
        check_seq(38'h25_0123_4567, 4);
        consume();

        // ---------------- reset during SDR bit 17 ----------------
        issue(2'b11, 38'h33_CCCC_3333);
        begin
            bit reached = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if ((n_bits - b_bits) == 18) begin
                    reached = 1'b1;
                    break;
                end
                tick();
            end
            check("reach_bit17", 64'(reached), 64'd1);
        end
        reset = 1'b1;
        tick();
        check("rst_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
        check("rst_tck", 64'(vji_tck), 64'd0);
        check("rst_tdi", 64'(vji_tdi), 64'd0);
        check("rst_ir_in", 64'(vji_ir_in), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        reset = 1'b0;
        repeat (250) tick();
        check("rst_no_udr", 64'(n_udr - b_udr), 64'd0);
        check("rst_no_rsp", 64'(n_rspv - b_rspv), 64'd0);

        // after reset the IR history is gone, so UIR is always issued
        issue(2'b11, 38'h12_3456_789A);
        wait_rsp(lat);
        check("post_rst_latency", 64'(lat), 64'(c_LAT_FULL));
        check("post_rst_data", 64'(rsp_data), 64'(38'h12_3456_789A));
        check_seq(38'h12_3456_789A, 4);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
